// File: rtl/tap_tempo.sv
// Tap-tempo meter: times the interval between tap presses and converts it to
// beats per minute with a bit-serial restoring divider.
module tap_tempo #(
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int MIN_BPM     = 30,
    parameter int MAX_BPM     = 300,
    parameter int DEFAULT_BPM = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tap,
    output logic [13:0] bpm,
    output logic        bpm_valid,
    output logic        tapping
);

    localparam logic [63:0] DIVIDEND_W = 64'(CLOCK_FREQ) * 64'd60;
    localparam logic [31:0] DIVIDEND   = DIVIDEND_W[31:0];
    localparam logic [31:0] MIN_PERIOD = DIVIDEND / 32'(MAX_BPM);
    localparam logic [31:0] TIMEOUT    = DIVIDEND / 32'(MIN_BPM);
    localparam logic [31:0] MIN_Q      = 32'(MIN_BPM);
    localparam logic [31:0] MAX_Q      = 32'(MAX_BPM);
    localparam logic [13:0] DEFAULT_Q  = 14'(DEFAULT_BPM);

    typedef enum logic {IDLE, MEASURE} state_t;
    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

    state_t      state_reg;
    div_state_t  div_state_reg;
    logic        tap_d_reg;
    logic        armed_reg;
    logic [31:0] count_reg;
    logic [31:0] quot_reg;
    logic [31:0] rem_reg;
    logic [31:0] divisor_reg;
    logic [5:0]  iter_reg;
    logic [13:0] bpm_reg;
    logic        bpm_valid_reg;
    logic        tapping_reg;

    logic        tap_event;
    logic        period_ok;
    logic        accept;
    logic        div_start;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [13:0] bpm_clamped;

    // armed_reg blocks a level that was already high when reset released
    assign tap_event = tap & ~tap_d_reg & armed_reg;
    assign period_ok = (count_reg >= MIN_PERIOD) && (count_reg <= TIMEOUT);
    assign accept    = (state_reg == MEASURE) && tap_event && period_ok;
    assign div_start = accept && (div_state_reg == DIV_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tap_d_reg <= 1'b0;
            armed_reg <= 1'b0;
        end else begin
            tap_d_reg <= tap;
            if (!tap) begin
                armed_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            count_reg   <= '0;
            tapping_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (tap_event) begin
                        count_reg   <= '0;
                        state_reg   <= MEASURE;
                        tapping_reg <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (accept) begin
                        count_reg <= '0;
                    end else if (!tap_event && count_reg == TIMEOUT) begin
                        state_reg   <= IDLE;
                        tapping_reg <= 1'b0;
                    end else if (count_reg != '1) begin
                        count_reg <= count_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    tapping_reg <= 1'b0;
                end
            endcase
        end
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign rem_shift = {rem_reg, quot_reg[31]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};

    always_comb begin
        bpm_clamped = quot_reg[13:0];
        if (quot_reg < MIN_Q) begin
            bpm_clamped = MIN_Q[13:0];
        end else if (quot_reg > MAX_Q) begin
            bpm_clamped = MAX_Q[13:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_state_reg <= DIV_IDLE;
            quot_reg      <= '0;
            rem_reg       <= '0;
            divisor_reg   <= '0;
            iter_reg      <= '0;
            bpm_reg       <= DEFAULT_Q;
            bpm_valid_reg <= 1'b0;
        end else begin
            bpm_valid_reg <= 1'b0;
            case (div_state_reg)
                DIV_IDLE: begin
                    if (div_start) begin
                        quot_reg      <= DIVIDEND;
                        rem_reg       <= '0;
                        divisor_reg   <= count_reg;
                        iter_reg      <= '0;
                        div_state_reg <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (iter_reg == 6'd32) begin
                        bpm_reg       <= bpm_clamped;
                        bpm_valid_reg <= 1'b1;
                        div_state_reg <= DIV_IDLE;
                    end else begin
                        if (!rem_diff[32]) begin
                            rem_reg  <= rem_diff[31:0];
                            quot_reg <= {quot_reg[30:0], 1'b1};
                        end else begin
                            rem_reg  <= rem_shift[31:0];
                            quot_reg <= {quot_reg[30:0], 1'b0};
                        end
                        iter_reg <= iter_reg + 6'd1;
                    end
                end
                default: begin
                    div_state_reg <= DIV_IDLE;
                end
            endcase
        end
    end

    assign bpm       = bpm_reg;
    assign bpm_valid = bpm_valid_reg;
    assign tapping   = tapping_reg;

endmodule

// File: tb/tb_tap_tempo.sv
// Bench for tap_tempo: an event-time reference model checked every cycle,
// directed tempo scenarios with literal expectations, then random tapping.
module tb_tap_tempo;

    localparam int CF    = 1000;
    localparam int MINB  = 30;
    localparam int MAXB  = 300;
    localparam int DEFB  = 120;
    localparam int DIVD  = CF * 60;
    localparam int MINP  = DIVD / MAXB;
    localparam int TMO   = DIVD / MINB;
    localparam int LAT   = 33;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tap   = 1'b0;
    logic [13:0] bpm;
    logic        bpm_valid;
    logic        tapping;

    tap_tempo #(
        .CLOCK_FREQ (CF),
        .MIN_BPM    (MINB),
        .MAX_BPM    (MAXB),
        .DEFAULT_BPM(DEFB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .tap      (tap),
        .bpm      (bpm),
        .bpm_valid(bpm_valid),
        .tapping  (tapping)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int last_ev = 0;
    int pulse_v[$];
    int pulse_t[$];

    // Reference model state, expressed as event times rather than counters
    bit m_last;
    bit m_meas;
    int m_restart;
    bit m_busy;
    int m_load;
    int m_res;
    int m_bpm;
    bit m_valid;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic int tempo_of(input int period);
        int q;
        q = DIVD / period;
        if (q < MINB) q = MINB;
        if (q > MAXB) q = MAXB;
        return q;
    endfunction

    initial begin
        bit ev;
        bit busy_before;
        int cnt;
        forever begin
            @(posedge clock);
            cyc++;
            if (!reset) begin
                m_last  = 1'b1;
                m_meas  = 1'b0;
                m_busy  = 1'b0;
                m_bpm   = DEFB;
                m_valid = 1'b0;
            end else begin
                ev          = tap && !m_last;
                m_last      = tap;
                m_valid     = 1'b0;
                busy_before = m_busy;
                if (m_busy && cyc == m_load + LAT) begin
                    m_bpm   = m_res;
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                end
                if (m_meas) begin
                    cnt = cyc - m_restart - 1;
                    if (ev && cnt >= MINP && cnt <= TMO) begin
                        m_restart = cyc;
                        if (!busy_before) begin
                            m_busy = 1'b1;
                            m_load = cyc;
                            m_res  = tempo_of(cnt);
                        end
                    end else if (!ev && cnt >= TMO) begin
                        m_meas = 1'b0;
                    end
                end else if (ev) begin
                    m_meas    = 1'b1;
                    m_restart = cyc;
                end
            end
            #1;
            check("bpm", int'(bpm), m_bpm);
            check("bpm_valid", int'(bpm_valid), int'(m_valid));
            check("tapping", int'(tapping), int'(m_meas));
            if (bpm_valid) begin
                pulse_v.push_back(int'(bpm));
                pulse_t.push_back(cyc);
                $display("pulse bpm=%0d cycle=%0d", bpm, cyc);
            end
        end
    end

    // Tap high for one edge; last_ev is the edge at which the event lands
    task automatic pulse();
        tap = 1'b1;
        @(negedge clock);
        last_ev = cyc;
        tap = 1'b0;
    endtask

    // Next event lands when the interval counter reads n
    task automatic tap_after(input int n);
        repeat (n) @(negedge clock);
        pulse();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pulse_v.delete();
        pulse_t.delete();
    endtask

    initial begin
        int acc[$];
        int exp_v[$];
        int a1;
        int a2;
        int gap;
        int width;

        repeat (3) @(negedge clock);
        check("reset_bpm", int'(bpm), DEFB);
        check("reset_tapping", int'(tapping), 0);
        check("reset_valid", int'(bpm_valid), 0);
        reset = 1'b1;
        @(negedge clock);

        // Tempo sequence: 120, 125, 300, rejected, 125, 30, timeout, 120
        pulse();
        check("tapping_after_first_tap", int'(tapping), 1);
        tap_after(500);  acc.push_back(last_ev);
        tap_after(480);  acc.push_back(last_ev);
        tap_after(200);  acc.push_back(last_ev);
        tap_after(199);
        tap_after(280);  acc.push_back(last_ev);
        tap_after(2000); acc.push_back(last_ev);
        repeat (2000) @(negedge clock);
        check("tapping_at_timeout_minus1", int'(tapping), 1);
        @(negedge clock);
        check("tapping_after_timeout", int'(tapping), 0);
        pulse();
        check("tapping_after_restart", int'(tapping), 1);
        tap_after(500);  acc.push_back(last_ev);
        repeat (40) @(negedge clock);
        exp_v = '{120, 125, 300, 125, 30, 120};
        check("seq_pulse_count", pulse_v.size(), 6);
        for (int i = 0; i < 6 && i < pulse_v.size(); i++) begin
            check("seq_pulse_bpm", pulse_v[i], exp_v[i]);
            check("seq_pulse_latency", pulse_t[i], acc[i] + LAT);
        end

        // Third tap lands 10 cycles into the division, below the minimum period
        do_reset();
        pulse();
        tap_after(200); a1 = last_ev;
        tap_after(9);
        tap_after(490); a2 = last_ev;
        repeat (40) @(negedge clock);
        check("busy_pulse_count", pulse_v.size(), 2);
        if (pulse_v.size() == 2) begin
            check("busy_first_bpm", pulse_v[0], 300);
            check("busy_first_time", pulse_t[0], a1 + LAT);
            check("busy_second_bpm", pulse_v[1], 120);
            check("busy_second_time", pulse_t[1], a2 + LAT);
        end

        // Reset mid-division with tap held across release
        do_reset();
        pulse();
        tap_after(200);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        tap = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_no_pulse", pulse_v.size(), 0);
        check("abort_bpm", int'(bpm), DEFB);
        check("abort_tapping_held", int'(tapping), 0);
        tap = 1'b0;
        @(negedge clock);
        tap = 1'b1;
        @(negedge clock);
        check("abort_tapping_toggle", int'(tapping), 1);
        tap = 1'b0;

        // Random tapping, including bounces, held levels and stray resets
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) gap = $urandom_range(1, 60);
            else gap = $urandom_range(150, 2100);
            width = $urandom_range(1, 3);
            repeat (gap) @(negedge clock);
            tap = 1'b1;
            repeat (width) @(negedge clock);
            tap = 1'b0;
            if ($urandom_range(0, 14) == 0) begin
                reset = 1'b0;
                repeat (2) @(negedge clock);
                reset = 1'b1;
            end
        end
        repeat (50) @(negedge clock);
        check("random_pulses_seen", int'(pulse_v.size() > 0), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
